// File: rtl/dbg_checkpoint_reader.sv
// dbg_checkpoint_reader: halts the core, snapshots its GPRs over the debug bus, then resumes it
module dbg_checkpoint_reader #(
  parameter int          NUM_REGS     = 32,
  parameter logic [14:0] GPR_BASE     = 15'h0400,
  parameter int          HALT_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        debug_halt_o,
  output logic        debug_resume_o,
  input  logic        debug_halted_i,
  output logic        debug_req_o,
  input  logic        debug_gnt_i,
  input  logic        debug_rvalid_i,
  output logic [14:0] debug_addr_o,
  output logic        debug_we_o,
  input  logic [31:0] debug_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  input  logic [4:0]  rd_idx_i,
  output logic [31:0] rd_data_o
);
  localparam int CW = $clog2(HALT_TIMEOUT + 2);
  typedef enum logic [2:0] {IDLE, HALT, REQ, WAIT_RV, RESUME, WAIT_RUN} state_t;
  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   snap_q [NUM_REGS];
  logic [31:0]   snap_d [NUM_REGS];
  logic          halt_q, halt_d, resume_q, resume_d, req_q, req_d;
  logic          busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic [14:0]   addr_q, addr_d;
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = HALT;
        cnt_d   = '0;
      end
      HALT: begin
        idx_d = '0;
        cnt_d = cnt_q + 1'b1;
        if (debug_halted_i) state_d = REQ;
        else if (cnt_q == CW'(HALT_TIMEOUT)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      REQ: if (debug_gnt_i) state_d = WAIT_RV;
      WAIT_RV: if (debug_rvalid_i) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (idx_q == 5'(i)) snap_d[i] = debug_rdata_i;
        state_d = (idx_q == 5'(NUM_REGS - 1)) ? RESUME : REQ;
        idx_d   = (idx_q == 5'(NUM_REGS - 1)) ? idx_q : idx_q + 5'd1;
      end
      RESUME: state_d = WAIT_RUN;
      WAIT_RUN: if (!debug_halted_i) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with state_q
    halt_d   = state_d == HALT;
    resume_d = state_d == RESUME;
    req_d    = state_d == REQ;
    busy_d   = state_d != IDLE;
    addr_d   = GPR_BASE + {8'b0, idx_d, 2'b00};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      snap_q    <= '{default: '0};
      halt_q    <= 1'b0;
      resume_q  <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      halt_q    <= halt_d;
      resume_q  <= resume_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      addr_q    <= req_d ? addr_d : '0;
    end
  end
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_idx_i == 5'(i)) rd_data_o = snap_q[i];
  end
  assign debug_halt_o   = halt_q;
  assign debug_resume_o = resume_q;
  assign debug_req_o    = req_q;
  assign debug_addr_o   = addr_q;
  assign debug_we_o     = 1'b0;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign timeout_o      = timeout_q;
endmodule
